// File: rtl/detect_log_pkg.sv
// Shared types and default parameters for the detect event logger.
//   log_state_t : window FSM state (IDLE, COUNT)
//   evt_rec_t   : one per-window record {alarm, count} at the default count width
//   CNT_W, DEF_WINDOW, DEF_THRESH, DEF_DEPTH : default configuration values
package detect_log_pkg;
  localparam int CNT_W      = 8;
  localparam int DEF_WINDOW = 16;
  localparam int DEF_THRESH = 3;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [0:0] {IDLE, COUNT} log_state_t;

  typedef struct packed {
    logic             alarm;
    logic [CNT_W-1:0] count;
  } evt_rec_t;
endpackage

// File: rtl/evt_rec_fifo.sv
// Synchronous record FIFO.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and record; ignored when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head record (meaningful only while empty=0)
//   full/empty : occupancy flags
module evt_rec_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   used;
  logic          push_ok, pop_ok;

  assign full  = (used == (AW+1)'(DEPTH));
  assign empty = (used == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end
endmodule

// File: rtl/detect_event_logger.sv
// Counts detect pulses over windows of WINDOW enabled cycles and queues one
// {alarm, count} record per completed window for a valid/ready consumer.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : window counting enable; dropping it discards the partial window
//   evt_in       : detect pulse, one event per high cycle
//   out_valid    : head record available
//   out_ready    : consumer accepts the head record
//   out_count    : head record event count (0 while empty)
//   out_alarm    : head record alarm flag (0 while empty)
//   drop_sticky  : a record was lost to a full FIFO
//   clear_drop   : clears drop_sticky (a same-cycle drop wins)
// Handshake: a record transfers on every rising edge where out_valid and
// out_ready are both high; head data holds steady while out_valid=1 and
// out_ready=0.
module detect_event_logger
  import detect_log_pkg::*;
#(
  parameter int WINDOW = detect_log_pkg::DEF_WINDOW,
  parameter int CNT_W  = detect_log_pkg::CNT_W,
  parameter int THRESH = detect_log_pkg::DEF_THRESH,
  parameter int DEPTH  = detect_log_pkg::DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             evt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_alarm,
  output logic             drop_sticky,
  input  logic             clear_drop
);
  localparam int WCW = $clog2(WINDOW);

  log_state_t       state, state_n;
  logic [WCW-1:0]   wcnt, wcnt_n;
  logic [CNT_W-1:0] ecnt, ecnt_n, rec_count;
  logic [CNT_W:0]   sum;
  logic             last, push, pop, full, empty, rec_alarm, drop;
  logic [CNT_W:0]   rec, head;

  always_comb begin
    // Saturating count including this cycle's pulse; on the last window
    // cycle this is the record value, otherwise the next ecnt.
    sum       = {1'b0, ecnt} + {{CNT_W{1'b0}}, evt_in};
    rec_count = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    rec_alarm = ({{(32-CNT_W){1'b0}}, rec_count} >= 32'(THRESH));
    last      = (state == COUNT) && (wcnt == WCW'(WINDOW-1));

    state_n = state;
    wcnt_n  = wcnt;
    ecnt_n  = ecnt;
    push    = 1'b0;
    case (state)
      IDLE: begin
        wcnt_n = '0;
        ecnt_n = '0;
        if (enable) state_n = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_n = IDLE;
          wcnt_n  = '0;
          ecnt_n  = '0;
        end else if (last) begin
          // Window closes here; the next one starts with no gap cycle.
          push   = 1'b1;
          wcnt_n = '0;
          ecnt_n = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
          ecnt_n = rec_count;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      ecnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      ecnt  <= ecnt_n;
    end
  end

  assign rec  = {rec_alarm, rec_count};
  assign pop  = !empty && out_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset)           drop_sticky <= 1'b0;
    else if (drop)       drop_sticky <= 1'b1;
    else if (clear_drop) drop_sticky <= 1'b0;
  end

  evt_rec_fifo #(.W(CNT_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs read as zero while nothing is buffered.
  assign out_valid = !empty;
  assign out_count = empty ? '0 : head[CNT_W-1:0];
  assign out_alarm = empty ? 1'b0 : head[CNT_W];
endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;
  logic       clk = 1'b0;
  logic       reset, enable, evt_in, out_ready, clear_drop;
  logic       out_valid, out_alarm, drop_sticky;
  logic [7:0] out_count;
  // Narrow-count instance used for the saturation case.
  logic       enable2, evt2, ready2, clear2;
  logic       out_valid2, out_alarm2, drop2;
  logic [1:0] out_count2;

  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  detect_event_logger dut (
    .clk(clk), .reset(reset), .enable(enable), .evt_in(evt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_alarm(out_alarm), .drop_sticky(drop_sticky), .clear_drop(clear_drop)
  );

  detect_event_logger #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .evt_in(evt2),
    .out_valid(out_valid2), .out_ready(ready2), .out_count(out_count2),
    .out_alarm(out_alarm2), .drop_sticky(drop2), .clear_drop(clear2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Monitors: pop an expected record on every accepted transfer.
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rec_unexpected got count=%0d alarm=%0d required none", out_count, out_alarm);
        end else begin
          e = exp_q.pop_front();
          if ({out_alarm, out_count} !== e) begin
            fails++;
            $display("FAIL rec got count=%0d alarm=%0d required count=%0d alarm=%0d",
                     out_count, out_alarm, e[7:0], e[8]);
          end
        end
      end
    end
  endtask

  task automatic monitor2();
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (out_valid2 && ready2) begin
        tests++;
        if (exp2_q.size() == 0) begin
          fails++;
          $display("FAIL rec2_unexpected got count=%0d alarm=%0d required none", out_count2, out_alarm2);
        end else begin
          e = exp2_q.pop_front();
          if ({out_alarm2, out_count2} !== e) begin
            fails++;
            $display("FAIL rec2 got count=%0d alarm=%0d required count=%0d alarm=%0d",
                     out_count2, out_alarm2, e[1:0], e[2]);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #1000000;
    fails++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  endtask

  task automatic start();
    enable = 1'b1;
    cyc();
  endtask

  task automatic stop();
    enable = 1'b0;
    evt_in = 1'b0;
    cyc();
  endtask

  // One full window with the FSM already counting. exp_rec is {alarm, count}
  // and is queued only when the record is expected to reach the consumer.
  task automatic run_window(input logic [15:0] mask, input logic [8:0] exp_rec,
                            input bit keep, input bit clr_last, input bit rdy_last);
    logic saved_ready;
    saved_ready = out_ready;
    if (keep) exp_q.push_back(exp_rec);
    for (int i = 0; i < 16; i++) begin
      evt_in = mask[i];
      if (i == 15) begin
        if (clr_last) clear_drop = 1'b1;
        if (rdy_last) out_ready = 1'b1;
      end
      cyc();
    end
    evt_in     = 1'b0;
    clear_drop = 1'b0;
    out_ready  = saved_ready;
  endtask

  initial begin
    fork
      monitor();
      monitor2();
      watchdog();
    join_none

    reset = 1'b1; enable = 1'b0; evt_in = 1'b0; out_ready = 1'b0; clear_drop = 1'b0;
    enable2 = 1'b0; evt2 = 1'b0; ready2 = 1'b1; clear2 = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check("reset_valid", out_valid, 0);
    check("reset_count", out_count, 0);
    check("reset_alarm", out_alarm, 0);
    check("reset_drop", drop_sticky, 0);
    check("reset_valid2", out_valid2, 0);

    // Single window, events on cycles 2, 5, 9.
    out_ready = 1'b1;
    start();
    run_window(16'h0224, 9'h103, 1, 0, 0);
    check("t1_valid_rise", out_valid, 1);
    stop();
    check("t1_valid_one_cycle", out_valid, 0);

    // Last-cycle event belongs to the ending window only.
    start();
    run_window(16'h0088, 9'h002, 1, 0, 0);
    run_window(16'h8010, 9'h002, 1, 0, 0);
    run_window(16'h0000, 9'h000, 1, 0, 0);
    stop();
    cyc();

    // Saturation with a 2-bit count.
    enable2 = 1'b1;
    cyc();
    exp2_q.push_back(3'b111);
    evt2 = 1'b1;
    repeat (16) cyc();
    evt2 = 1'b0; enable2 = 1'b0;
    cyc(); cyc();
    check("sat_drained", out_valid2, 0);

    // Five windows with no consumer: fifth record dropped.
    out_ready = 1'b0;
    start();
    run_window(16'h0001, 9'h001, 1, 0, 0);
    run_window(16'h0003, 9'h002, 1, 0, 0);
    run_window(16'h0007, 9'h103, 1, 0, 0);
    run_window(16'h000F, 9'h104, 1, 0, 0);
    check("full_no_drop_yet", drop_sticky, 0);
    run_window(16'h001F, 9'h000, 0, 0, 0);
    check("drop_set", drop_sticky, 1);
    check("head_stable_count", out_count, 1);
    stop();
    out_ready = 1'b1;
    repeat (4) cyc();
    check("drained_1", out_valid, 0);
    clear_drop = 1'b1;
    cyc();
    clear_drop = 1'b0;
    check("drop_cleared", drop_sticky, 0);

    // Drop and clear in the same cycle: set wins.
    out_ready = 1'b0;
    start();
    run_window(16'h001F, 9'h105, 1, 0, 0);
    run_window(16'h003F, 9'h106, 1, 0, 0);
    run_window(16'h007F, 9'h107, 1, 0, 0);
    run_window(16'h00FF, 9'h108, 1, 0, 0);
    check("full2_no_drop", drop_sticky, 0);
    run_window(16'h03FF, 9'h000, 0, 1, 0);
    check("drop_set_wins", drop_sticky, 1);
    stop();
    clear_drop = 1'b1;
    cyc();
    clear_drop = 1'b0;
    check("drop_cleared2", drop_sticky, 0);

    // FIFO full, pop on the exact push cycle: no drop.
    start();
    run_window(16'h01FF, 9'h109, 1, 0, 1);
    check("pop_push_full_no_drop", drop_sticky, 0);
    check("pop_push_full_valid", out_valid, 1);
    check("pop_push_full_head", out_count, 6);
    stop();
    out_ready = 1'b1;
    repeat (4) cyc();
    check("drained_2", out_valid, 0);

    // Enable dropped mid-window: partial window discarded.
    start();
    for (int i = 0; i < 7; i++) begin
      evt_in = (i == 1 || i == 4);
      cyc();
    end
    stop();
    check("partial_wcnt", 32'(dut.wcnt), 0);
    check("partial_ecnt", 32'(dut.ecnt), 0);
    cyc(); cyc();
    check("partial_no_record", out_valid, 0);
    start();
    run_window(16'h0100, 9'h001, 1, 0, 0);
    stop();
    cyc();

    // Reset with two records buffered and a window in progress.
    out_ready = 1'b0;
    start();
    run_window(16'h0003, 9'h002, 0, 0, 0);
    run_window(16'h0007, 9'h103, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      evt_in = (i == 2 || i == 6);
      cyc();
    end
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_head", out_count, 2);
    check("pre_reset_ecnt", 32'(dut.ecnt), 2);
    reset = 1'b1; enable = 1'b0; evt_in = 1'b0;
    cyc();
    reset = 1'b0;
    check("post_reset_valid", out_valid, 0);
    check("post_reset_count", out_count, 0);
    check("post_reset_wcnt", 32'(dut.wcnt), 0);
    check("post_reset_ecnt", 32'(dut.ecnt), 0);
    check("post_reset_drop", drop_sticky, 0);
    out_ready = 1'b1;
    cyc(); cyc();

    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("exp2_q_empty", 32'(exp2_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/detect_event_logger.md
Name: detect_event_logger

Overview:
Downstream consumer of the sequence detector's single-cycle Q pulse. Counts detect pulses over fixed windows of WINDOW enabled cycles and builds one record per window: a saturated count plus an alarm flag when the count reaches THRESH. Records are buffered in a small FIFO and drained over a valid/ready interface toward the status/telemetry path.

Parameters:
WINDOW, 16, window length in enabled clock cycles (>=2)
CNT_W, 8, width of the per-window event count
THRESH, 3, alarm threshold; alarm = (count >= THRESH)
DEPTH, 4, record FIFO depth (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  window counting enable
evt_in  in  1  detect pulse from the sequence detector (Q); one event per high cycle
out_valid  out  1  record available at FIFO head
out_ready  in  1  consumer accepts the head record
out_count  out  CNT_W  head record event count
out_alarm  out  1  head record alarm flag
drop_sticky  out  1  set when a record was lost to a full FIFO
clear_drop  in  1  clears drop_sticky

Behaviour:
- Reset: synchronous, active-high; all state is cleared on the clock edge with reset high. After reset: FSM=IDLE, window counter=0, event counter=0, FIFO empty, out_valid=0, out_count=0, out_alarm=0, drop_sticky=0. Reset mid-window discards the partial window and all buffered records.
- FSM states IDLE and COUNT.
  - IDLE: counters held at 0; evt_in ignored. Goes to COUNT on the cycle after enable=1 is sampled.
  - COUNT: wcnt increments by 1 each cycle; ecnt increments when evt_in=1.
  - COUNT to IDLE: enable=0 is sampled. The partial window is discarded, no record is pushed, and the counters are cleared.
- Window boundaries:
  - The cycle in COUNT with wcnt==WINDOW-1 is the last cycle of the window.
  - That cycle's record count is ecnt + evt_in, saturating at 2^CNT_W-1. It is pushed to the FIFO at that clock edge.
  - ecnt then restarts from 0 and wcnt from 0. A new window begins on the next cycle with no gap cycle.
  - Every window is exactly WINDOW cycles long, and every evt_in=1 cycle in COUNT belongs to exactly one window.
- Saturation: ecnt never wraps; it holds at its maximum value.
- Alarm: computed at push time as final count >= THRESH and stored in the record.
- FIFO and handshake:
  - out_valid = FIFO not empty; out_count and out_alarm always reflect the head record.
  - A pop occurs when out_valid && out_ready.
  - Latency: out_valid rises 1 cycle after the push edge when the FIFO was empty.
  - Head data is stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle with the FIFO empty: the push is accepted; there is no bypass.
  - Push and pop in the same cycle with the FIFO full: the pop frees the slot, the push is accepted, and there is no drop.
  - Push with the FIFO full and no pop: the new record is dropped and drop_sticky is set on the next edge. The FIFO contents are unchanged.
- drop_sticky: cleared by clear_drop=1. If a set and a clear occur in the same cycle, the set wins.

Decomposition:
- Package detect_log_pkg:
  - typedef enum logic [0:0] {IDLE, COUNT} log_state_t
  - typedef struct packed {logic alarm; logic [CNT_W-1:0] count;} evt_rec_t, with CNT_W exported as a package localparam default
  - Default localparams for WINDOW, THRESH and DEPTH.
- Sub-module evt_rec_fifo: synchronous FIFO of evt_rec_t with push/pop, full/empty, simultaneous push/pop-when-full support and synchronous active-high reset.
- Top module holds the FSM, counters, alarm compare and sticky flag.

Test Plan:
- Reset, enable=1 for 16 cycles, evt_in=1 on cycles 2, 5 and 9, out_ready=1 -> one record {count=3, alarm=1}; out_valid high for exactly 1 cycle, starting 1 cycle after the window's last cycle.
- Window with 2 events, then evt_in=1 on the last cycle of the next window (cycle 15 of that window) plus 1 earlier event -> records {2,0} then {2,0}; the last-cycle event is counted in the ending window and not in the following one.
- out_ready=0 with 5 consecutive full windows -> first 4 records retained in order; 5th dropped; drop_sticky=1. Then out_ready=1 drains the 4 records. clear_drop=1 clears the flag; clear_drop asserted in the same cycle as a new drop leaves drop_sticky=1.
- FIFO full, out_ready=1 on the exact push cycle of a new record -> no drop; that record becomes the 4th entry after the pop.
- CNT_W=2, evt_in=1 for an entire window -> count saturates at 3, alarm=1.
- enable dropped at window cycle 7 with 2 events, then re-enabled -> no record pushed; next record counts only events after re-enable. reset at window cycle 10 with 2 records buffered -> out_valid=0 and all counters 0 on the next cycle.
